// File: rtl/fwd_stall_unit.sv
// ID-stage operand forwarding, load-use / MEM-wait stall generation, WB history buffer and stuck-load watchdog.
// Optional performance counters (StallCycles, FwdHits) are built only when FWD_PERF_CNT_EN is defined.

module fwd_stall_unit #(
  parameter int DATA_W    = 32,
  parameter int NUM_READ  = 2,
  parameter int RF_WR_LAT = 2,
  parameter int TIMEOUT   = 255,
  parameter int WAIT_W    = 8
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic [NUM_READ*5-1:0]      IDReadRegister,
  input  logic [NUM_READ-1:0]        IDReadEnable,
  input  logic [NUM_READ*DATA_W-1:0] IDRegisterData,
  input  logic [4:0]                 EXWriteRegister,
  input  logic                       EXWriteEnable,
  input  logic                       EXIsLoad,
  input  logic [DATA_W-1:0]          EXWriteData,
  input  logic [4:0]                 MEMWriteRegister,
  input  logic                       MEMWriteEnable,
  input  logic                       MEMIsLoad,
  input  logic [DATA_W-1:0]          MEMWriteData,
  input  logic [DATA_W-1:0]          MEMDramData,
  input  logic                       MEMDramValid,
  input  logic [4:0]                 WBWriteRegister,
  input  logic                       WBWriteEnable,
  input  logic [DATA_W-1:0]          WBWriteData,
  output logic [NUM_READ*DATA_W-1:0] NewRegisterData,
  output logic                       LoadUseStall,
  output logic                       MemStall,
  output logic                       HazardError
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]                StallCycles,
  output logic [31:0]                FwdHits
`endif
);

  // With no write latency a single always-invalid entry keeps the lookup logic uniform.
  localparam int HL = (RF_WR_LAT > 0) ? RF_WR_LAT : 1;
  localparam logic [WAIT_W-1:0] TO_V = WAIT_W'(TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  logic              hist_v [HL];
  logic [4:0]        hist_r [HL];
  logic [DATA_W-1:0] hist_d [HL];

  logic [NUM_READ-1:0] ex_hit;
  logic [NUM_READ-1:0] mem_hit;
  logic [NUM_READ-1:0] wb_hit;
  logic [DATA_W-1:0]   mem_fwd;
  logic                ld_use_raw;
  logic                mem_stall_raw;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  generate
    if (RF_WR_LAT > 0) begin : g_hist
      always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
          for (int j = 0; j < HL; j++) begin
            hist_v[j] <= 1'b0;
            hist_r[j] <= '0;
            hist_d[j] <= '0;
          end
        end else begin
          hist_v[0] <= WBWriteEnable && (WBWriteRegister != 5'd0);
          hist_r[0] <= WBWriteRegister;
          hist_d[0] <= WBWriteData;
          for (int j = 1; j < HL; j++) begin
            hist_v[j] <= hist_v[j-1];
            hist_r[j] <= hist_r[j-1];
            hist_d[j] <= hist_d[j-1];
          end
        end
      end
    end else begin : g_no_hist
      always_comb begin
        for (int j = 0; j < HL; j++) begin
          hist_v[j] = 1'b0;
          hist_r[j] = '0;
          hist_d[j] = '0;
        end
      end
    end
  endgenerate

  assign mem_fwd = MEMIsLoad ? MEMDramData : MEMWriteData;

`ifdef FWD_PERF_CNT_EN
  logic [NUM_READ-1:0] fwd_hit;
`endif

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_port
    logic [4:0]        rd;
    logic              rd_ok;
    logic              h_hit;
    logic [DATA_W-1:0] h_dat;
    logic [DATA_W-1:0] sel;

    assign rd          = IDReadRegister[gi*5 +: 5];
    assign rd_ok       = IDReadEnable[gi] && (rd != 5'd0);
    assign ex_hit[gi]  = rd_ok && EXWriteEnable  && (EXWriteRegister  == rd);
    assign mem_hit[gi] = rd_ok && MEMWriteEnable && (MEMWriteRegister == rd);
    assign wb_hit[gi]  = rd_ok && WBWriteEnable  && (WBWriteRegister  == rd);

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
      h_hit = 1'b0;
      h_dat = '0;
      for (int j = HL - 1; j >= 0; j--) begin
        if (rd_ok && hist_v[j] && (hist_r[j] == rd)) begin
          h_hit = 1'b1;
          h_dat = hist_d[j];
        end
      end
    end

    always_comb begin
      sel = IDRegisterData[gi*DATA_W +: DATA_W];
      if (ex_hit[gi])       sel = EXWriteData;
      else if (mem_hit[gi]) sel = mem_fwd;
      else if (wb_hit[gi])  sel = WBWriteData;
      else if (h_hit)       sel = h_dat;
    end

    assign NewRegisterData[gi*DATA_W +: DATA_W] =
      cpu_rst ? IDRegisterData[gi*DATA_W +: DATA_W] : sel;

`ifdef FWD_PERF_CNT_EN
    assign fwd_hit[gi] = ex_hit[gi] || mem_hit[gi] || wb_hit[gi] || h_hit;
`endif
  end

  assign ld_use_raw    = (|ex_hit) && EXIsLoad;
  assign mem_stall_raw = MEMIsLoad && MEMWriteEnable && !MEMDramValid;

  assign LoadUseStall = !cpu_rst && ld_use_raw;
  assign MemStall     = !cpu_rst && mem_stall_raw;

  assign wait_nxt = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      HazardError <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall_raw) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!mem_stall_raw) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_nxt;
            if ((TIMEOUT != 0) && (wait_nxt == TO_V)) HazardError <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      StallCycles <= '0;
      FwdHits     <= '0;
    end else begin
      if (LoadUseStall || MemStall) StallCycles <= StallCycles + 32'd1;
      if (|fwd_hit)                 FwdHits     <= FwdHits + 32'd1;
    end
  end
`endif

endmodule
